// File: rtl/sec_min_counter.sv
// Purpose: seconds/minutes BCD time base; divides clk to a 1 Hz tick, counts 00:00..59:59, pulses cout on wrap.
// Latency: digits, tick and cout update on the edge where the prescaler wraps; a minutes load takes effect on the first edge after set_req rises.
// Backpressure: none on the count path; the minutes load is a four-phase set_req/set_ack handshake.
//
// Parameters:
//   CLK_DIV  clk cycles per second (>= 2)
//   DIV_W    prescaler width, 2**DIV_W >= CLK_DIV
// Ports:
//   clk, reset (async, active-low)
//   en        run enable; low freezes prescaler and digits
//   clr       synchronous clear of prescaler and digits (highest priority)
//   set_req / set_ack, set_min_l / set_min_h   minutes load handshake
//   sec_l, sec_h, min_l, min_h                 BCD digit outputs
//   tick      one-cycle pulse per second advance
//   cout      one-cycle pulse on 59:59 -> 00:00
//   blink     colon blink
// Optional feature macro: COLON_BLINK_EN (blink = 1 during the first half of each
// second); when undefined, blink is tied to 1 and no comparator exists.

module sec_min_counter #(
   parameter int CLK_DIV = 50000000,
   parameter int DIV_W   = 26
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       en,
   input  logic       clr,
   input  logic       set_req,
   input  logic [3:0] set_min_l,
   input  logic [3:0] set_min_h,
   output logic       set_ack,
   output logic [3:0] sec_l,
   output logic [3:0] sec_h,
   output logic [3:0] min_l,
   output logic [3:0] min_h,
   output logic       tick,
   output logic       cout,
   output logic       blink
);

   localparam logic [DIV_W-1:0] LAST = DIV_W'(CLK_DIV - 1);

   logic [DIV_W-1:0] cnt;
   logic [DIV_W-1:0] cnt_nxt;
   logic             load;
   logic             wrap;

   // A load is only accepted while the previous handshake has fully closed.
   assign load = set_req && !set_ack;
   assign wrap = en && !clr && !load && (cnt == LAST);

   always_comb begin
      cnt_nxt = cnt;
      if (clr || load) begin
         cnt_nxt = '0;
      end else if (en) begin
         cnt_nxt = (cnt == LAST) ? '0 : cnt + DIV_W'(1);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt     <= '0;
         sec_l   <= 4'd0;
         sec_h   <= 4'd0;
         min_l   <= 4'd0;
         min_h   <= 4'd0;
         tick    <= 1'b0;
         cout    <= 1'b0;
         set_ack <= 1'b0;
      end else begin
         cnt  <= cnt_nxt;
         tick <= wrap;
         cout <= wrap && (min_h == 4'd5) && (min_l == 4'd9)
                      && (sec_h == 4'd5) && (sec_l == 4'd9);

         // Acknowledge is released as soon as the requester drops set_req,
         // independent of clear; it is never raised while clear is active.
         if (!set_req) begin
            set_ack <= 1'b0;
         end else if (load && !clr) begin
            set_ack <= 1'b1;
         end

         if (clr) begin
            sec_l <= 4'd0;
            sec_h <= 4'd0;
            min_l <= 4'd0;
            min_h <= 4'd0;
         end else if (load) begin
            // Out-of-range digits are replaced by 0, each digit on its own.
            min_l <= (set_min_l > 4'd9) ? 4'd0 : set_min_l;
            min_h <= (set_min_h > 4'd5) ? 4'd0 : set_min_h;
            sec_l <= 4'd0;
            sec_h <= 4'd0;
         end else if (wrap) begin
            if (sec_l != 4'd9) begin
               sec_l <= sec_l + 4'd1;
            end else begin
               sec_l <= 4'd0;
               if (sec_h != 4'd5) begin
                  sec_h <= sec_h + 4'd1;
               end else begin
                  sec_h <= 4'd0;
                  if (min_l != 4'd9) begin
                     min_l <= min_l + 4'd1;
                  end else begin
                     min_l <= 4'd0;
                     min_h <= (min_h == 4'd5) ? 4'd0 : min_h + 4'd1;
                  end
               end
            end
         end
      end
   end

`ifdef COLON_BLINK_EN
   localparam logic [DIV_W-1:0] HALF = DIV_W'(CLK_DIV / 2);

   // Tracks the prescaler value it will sit beside, so it holds when en=0
   // and returns to 1 whenever clear or load zero the prescaler.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         blink <= 1'b1;
      end else begin
         blink <= (cnt_nxt < HALF);
      end
   end
`else
   assign blink = 1'b1;
`endif

endmodule

// File: tb/tb_sec_min_counter.sv
module tb_sec_min_counter;

   localparam int CLK_DIV = 4;
   localparam int DIV_W   = 4;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       en = 1'b0;
   logic       clr = 1'b0;
   logic       set_req = 1'b0;
   logic [3:0] set_min_l = 4'd0;
   logic [3:0] set_min_h = 4'd0;
   logic       set_ack;
   logic [3:0] sec_l, sec_h, min_l, min_h;
   logic       tick, cout, blink;

   int total = 0;
   int bad   = 0;

   // Reference model: elapsed seconds within the hour plus prescaler phase.
   int m_secs  = 0;
   int m_ph    = 0;
   bit m_ack   = 0;
   bit m_tick  = 0;
   bit m_cout  = 0;
   int cout_seen;

   sec_min_counter #(.CLK_DIV(CLK_DIV), .DIV_W(DIV_W)) dut (
      .clk(clk), .reset(reset), .en(en), .clr(clr),
      .set_req(set_req), .set_min_l(set_min_l), .set_min_h(set_min_h),
      .set_ack(set_ack), .sec_l(sec_l), .sec_h(sec_h),
      .min_l(min_l), .min_h(min_h), .tick(tick), .cout(cout), .blink(blink)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [15:0] exp_digits();
      int m, s;
      m = m_secs / 60;
      s = m_secs % 60;
      return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
   endfunction

   function automatic bit exp_blink();
`ifdef COLON_BLINK_EN
      return (m_ph < CLK_DIV / 2);
`else
      return 1'b1;
`endif
   endfunction

   task automatic model_reset();
      m_secs = 0; m_ph = 0; m_ack = 0; m_tick = 0; m_cout = 0;
   endtask

   task automatic model_edge();
      int l, h;
      m_tick = 0;
      m_cout = 0;
      if (clr) begin
         m_secs = 0;
         m_ph   = 0;
         if (!set_req) m_ack = 0;
      end else if (set_req && !m_ack) begin
         l = (set_min_l > 9) ? 0 : int'(set_min_l);
         h = (set_min_h > 5) ? 0 : int'(set_min_h);
         m_secs = (h * 10 + l) * 60;
         m_ph   = 0;
         m_ack  = 1;
      end else begin
         if (!set_req) m_ack = 0;
         if (en) begin
            if (m_ph == CLK_DIV - 1) begin
               m_ph   = 0;
               m_tick = 1;
               m_cout = (m_secs == 3599);
               m_secs = (m_secs + 1) % 3600;
            end else begin
               m_ph++;
            end
         end
      end
   endtask

   task automatic check_all(input string where);
      chk({where, ".digits"}, 32'({min_h, min_l, sec_h, sec_l}), 32'(exp_digits()));
      chk({where, ".tick"},   32'(tick),    32'(m_tick));
      chk({where, ".cout"},   32'(cout),    32'(m_cout));
      chk({where, ".ack"},    32'(set_ack), 32'(m_ack));
      chk({where, ".blink"},  32'(blink),   32'(exp_blink()));
   endtask

   task automatic step(input string where);
      @(posedge clk);
      model_edge();
      #1;
      if (cout) cout_seen++;
      check_all(where);
   endtask

   task automatic load_min(input int h, input int l, input string where);
      set_min_h = 4'(h);
      set_min_l = 4'(l);
      set_req = 1'b1;
      step(where);
      set_req = 1'b0;
      step(where);
   endtask

   initial begin
      // Reset state
      #2;
      model_reset();
      check_all("reset");
      #10;
      en = 1'b1;
      reset = 1'b1;

      // Free run from reset: ticks at cycles 4, 8, 12
      for (int i = 0; i < 12; i++) step("run");

      // Load 59 minutes and run one minute through the hour wrap
      en = 1'b0;
      load_min(5, 9, "load59");
      en = 1'b1;
      cout_seen = 0;
      for (int i = 0; i < 60 * CLK_DIV; i++) step("wrap");
      chk("wrap.cout_count", 32'(cout_seen), 32'd1);

      // set_req held five cycles: exactly one load
      set_min_h = 4'd2; set_min_l = 4'd3; set_req = 1'b1;
      for (int i = 0; i < 5; i++) step("hold_req");
      set_req = 1'b0;
      for (int i = 0; i < 3; i++) step("hold_rel");

      // Non-BCD load digits
      for (int i = 0; i < 3; i++) step("pre_bad");
      load_min(7, 12, "bad_bcd");

      // Pause at 00:07 for 20 cycles
      load_min(0, 0, "zero");
      for (int i = 0; i < 7 * CLK_DIV + 2; i++) step("to7");
      en = 1'b0;
      for (int i = 0; i < 20; i++) step("pause");
      en = 1'b1;
      for (int i = 0; i < 2 * CLK_DIV; i++) step("resume");

      // Clear on a prescaler-wrap cycle at 12:34
      load_min(1, 2, "load12");
      while (m_secs != 12 * 60 + 34) step("to1234");
      while (m_ph != CLK_DIV - 1) step("to_wrap");
      clr = 1'b1;
      step("clr_wrap");
      clr = 1'b0;
      for (int i = 0; i < 2 * CLK_DIV; i++) step("after_clr");

      // Clear and load together: clear wins, load on the next edge
      set_min_h = 4'd4; set_min_l = 4'd5; set_req = 1'b1; clr = 1'b1;
      step("clr_set");
      clr = 1'b0;
      step("set_after_clr");
      set_req = 1'b0;
      step("set_after_clr_rel");

      // Reset in the middle of a handshake, then a fresh load after release
      set_min_h = 4'd3; set_min_l = 4'd1; set_req = 1'b1;
      step("pre_rst");
      #2;
      reset = 1'b0;
      #1;
      model_reset();
      check_all("mid_rst");
      #3;
      reset = 1'b1;
      step("rst_reload");
      set_req = 1'b0;
      step("rst_reload_rel");

      // Randomized traffic
      for (int i = 0; i < 4000; i++) begin
         en = ($urandom_range(7) != 0);
         clr = ($urandom_range(99) == 0) && !(m_ack && !set_req);
         if (!set_req && !m_ack && $urandom_range(29) == 0) begin
            set_req = 1'b1;
            set_min_h = 4'($urandom_range(15));
            set_min_l = 4'($urandom_range(15));
            if ($urandom_range(1) == 1) begin
               set_min_h = 4'd5;
               set_min_l = 4'd9;
            end
         end else if (set_req && m_ack && $urandom_range(2) == 0) begin
            set_req = 1'b0;
         end
         step("rand");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
